ifu_pcgen: RTL and testbench

- Fetch-address generator and instruction register (IR) for the IFU.
- Issues one fetch request at a time to the fetch port and captures the response into the IR, which feeds the decoder and lite branch predictor.
- Computes the next PC from either the predictor's add operands or sequential increment, and handles pipeline flush redirects from the EXU.

---
 rtl/ifu_pcgen.sv | 130 +++++++++++++
 tb/tb_ifu_pcgen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_pcgen.sv
// ifu_pcgen: IFU fetch-address generator and instruction register.
// Keeps one fetch outstanding, captures the response into the IR and
// computes the next fetch PC from the predictor operands, the sequential
// increment or an EXU flush redirect.
module ifu_pcgen #(
  parameter int unsigned          PC_SIZE   = 32,
  parameter logic [PC_SIZE-1:0]   RESET_VEC = PC_SIZE'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [31:0]        ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic               ir_valid,
  output logic [31:0]        ir_instr,
  output logic [PC_SIZE-1:0] ir_pc,
  output logic               ir_err,
  input  logic               ir_ready,
  input  logic               dec_rv32,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               bpu_busy,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_pc,
  output logic               pipe_flush_ack
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_REQ      = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  state_e               state_q;
  logic [PC_SIZE-1:0]   pc_nxt_q;
  logic [PC_SIZE-1:0]   pc_nxt_d;
  logic                 ir_valid_q;
  logic [INSTR_W-1:0]   ir_instr_q;
  logic [PC_SIZE-1:0]   ir_pc_q;
  logic                 ir_err_q;
  logic                 discard_q;

  logic                 req_hsk;
  logic                 advance;
  logic [PC_SIZE-1:0]   seq_pc;
  logic [PC_SIZE-1:0]   prdt_pc;
  logic [PC_SIZE-1:0]   adv_pc;

  // Handshake / advance qualifiers and next-PC candidates (modulo 2^PC_SIZE)
  assign req_hsk = (state_q == ST_REQ) && ifu_req_ready;
  assign advance = (state_q == ST_HOLD) && ir_ready && !bpu_busy;
  assign seq_pc  = ir_pc_q + PC_SIZE'(dec_rv32 ? 3'd4 : 3'd2);
  assign prdt_pc = prdt_pc_add_op1 + prdt_pc_add_op2;
  assign adv_pc  = prdt_taken ? prdt_pc : seq_pc;

  // Next fetch PC: flush redirect wins over an IR advance; bit 0 always clear
  always_comb begin
    pc_nxt_d = pc_nxt_q;
    if (pipe_flush_req) begin
      pc_nxt_d = {pipe_flush_pc[PC_SIZE-1:1], 1'b0};
    end else if (advance) begin
      pc_nxt_d = {adv_pc[PC_SIZE-1:1], 1'b0};
    end
  end

  // Fetch FSM and IR; pc_nxt_q doubles as the PC of the in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_nxt_q   <= RESET_VEC;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
      ir_err_q   <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      pc_nxt_q <= pc_nxt_d;
      case (state_q)
        ST_REQ: begin
          if (req_hsk) begin
            state_q <= ST_WAIT_RSP;
            if (pipe_flush_req) discard_q <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (ifu_rsp_valid) begin
            if (pipe_flush_req || discard_q) begin
              discard_q <= 1'b0;
              state_q   <= ST_REQ;
            end else begin
              ir_instr_q <= ifu_rsp_instr;
              ir_err_q   <= ifu_rsp_err;
              ir_pc_q    <= pc_nxt_q;
              ir_valid_q <= 1'b1;
              state_q    <= ST_HOLD;
            end
          end else if (pipe_flush_req) begin
            discard_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (pipe_flush_req || advance) begin
            ir_valid_q <= 1'b0;
            state_q    <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_REQ;
        end
      endcase
    end
  end

  assign ifu_req_valid  = (state_q == ST_REQ);
  assign ifu_req_pc     = pc_nxt_q;
  assign ifu_rsp_ready  = (state_q == ST_WAIT_RSP);
  assign ir_valid       = ir_valid_q;
  assign ir_instr       = ir_instr_q;
  assign ir_pc          = ir_pc_q;
  assign ir_err         = ir_err_q;
  assign pipe_flush_ack = pipe_flush_req;

endmodule

// File: tb/tb_ifu_pcgen.sv
// tb_ifu_pcgen: directed bench for ifu_pcgen with expected-PC and expected-IR
// scoreboard queues filled when stimulus is driven.
module tb_ifu_pcgen;

  localparam int unsigned PC_SIZE = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_SIZE-1:0] ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic [31:0]        ifu_rsp_instr;
  logic               ifu_rsp_err;
  logic               ir_valid;
  logic [31:0]        ir_instr;
  logic [PC_SIZE-1:0] ir_pc;
  logic               ir_err;
  logic               ir_ready;
  logic               dec_rv32;
  logic               prdt_taken;
  logic [PC_SIZE-1:0] prdt_pc_add_op1;
  logic [PC_SIZE-1:0] prdt_pc_add_op2;
  logic               bpu_busy;
  logic               pipe_flush_req;
  logic [PC_SIZE-1:0] pipe_flush_pc;
  logic               pipe_flush_ack;

  ifu_pcgen #(.PC_SIZE(PC_SIZE), .RESET_VEC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .ir_valid(ir_valid), .ir_instr(ir_instr), .ir_pc(ir_pc), .ir_err(ir_err),
    .ir_ready(ir_ready), .dec_rv32(dec_rv32), .prdt_taken(prdt_taken),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
    .bpu_busy(bpu_busy), .pipe_flush_req(pipe_flush_req),
    .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ir_exp_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc_q[$];
  ir_exp_t     exp_ir_q[$];
  logic [31:0] cur_ir_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(output logic [31:0] pc);
    for (int i = 0; i < 20 && ifu_req_valid !== 1'b1; i++) step();
    chk("req_valid", 32'(ifu_req_valid), 32'd1);
    pc = (exp_pc_q.size() > 0) ? exp_pc_q.pop_front() : 32'hxxxx_xxxx;
    chk("req_pc", ifu_req_pc, pc);
  endtask

  task automatic check_ir();
    ir_exp_t x;
    x = (exp_ir_q.size() > 0) ? exp_ir_q.pop_front() : 'x;
    chk("ir_valid", 32'(ir_valid), 32'd1);
    chk("ir_pc", ir_pc, x.pc);
    chk("ir_instr", ir_instr, x.instr);
    chk("ir_err", 32'(ir_err), 32'(x.err));
    cur_ir_pc = x.pc;
  endtask

  task automatic do_fetch(input logic [31:0] instr, input logic err, input int dly);
    logic [31:0] pc;
    expect_req(pc);
    exp_ir_q.push_back('{pc: pc, instr: instr, err: err});
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("rsp_ready", 32'(ifu_rsp_ready), 32'd1);
    chk("req_valid_in_wait", 32'(ifu_req_valid), 32'd0);
    repeat (dly) step();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = instr;
    ifu_rsp_err   = err;
    step();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    check_ir();
  endtask

  task automatic advance(input logic rv32, input logic taken,
                         input logic [31:0] op1, input logic [31:0] op2);
    logic [31:0] n;
    n = taken ? (op1 + op2) : (cur_ir_pc + (rv32 ? 32'd4 : 32'd2));
    n[0] = 1'b0;
    exp_pc_q.push_back(n);
    ir_ready = 1'b1; dec_rv32 = rv32; prdt_taken = taken;
    prdt_pc_add_op1 = op1; prdt_pc_add_op2 = op2;
    step();
    ir_ready = 1'b0; prdt_taken = 1'b0;
    chk("ir_valid_after_adv", 32'(ir_valid), 32'd0);
    chk("req_valid_after_adv", 32'(ifu_req_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    ir_ready = 1'b0; dec_rv32 = 1'b0; prdt_taken = 1'b0;
    prdt_pc_add_op1 = '0; prdt_pc_add_op2 = '0; bpu_busy = 1'b0;
    pipe_flush_req = 1'b0; pipe_flush_pc = '0;
    cur_ir_pc = '0;
    repeat (2) step();
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_pc", ir_pc, 32'd0);
    chk("rst_ir_instr", ir_instr, 32'd0);
    chk("rst_ir_err", 32'(ir_err), 32'd0);
    chk("rst_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(ifu_req_valid), 32'd1);
    chk("flush_ack_idle", 32'(pipe_flush_ack), 32'd0);

    // Reset fetch, then sequential 32-bit and 16-bit advances
    exp_pc_q.push_back(32'h8000_0000);
    do_fetch(32'h0000_0013, 1'b0, 1);
    advance(1'b1, 1'b0, '0, '0);
    do_fetch(32'h0000_0002, 1'b0, 0);
    advance(1'b0, 1'b0, '0, '0);
    do_fetch(32'h0000_0003, 1'b0, 2);
    advance(1'b0, 1'b0, '0, '0);
    do_fetch(32'h0000_0004, 1'b0, 0);

    // Flush in HOLD beats a simultaneous taken-prediction advance
    ir_ready = 1'b1; prdt_taken = 1'b1;
    prdt_pc_add_op1 = 32'h0000_0100; prdt_pc_add_op2 = 32'h0000_0000;
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h8000_0007;
    #1;
    chk("flush_ack_hold", 32'(pipe_flush_ack), 32'd1);
    step();
    pipe_flush_req = 1'b0; ir_ready = 1'b0; prdt_taken = 1'b0;
    chk("hold_flush_ir_valid", 32'(ir_valid), 32'd0);
    exp_pc_q.push_back(32'h8000_0006);
    do_fetch(32'h0000_0005, 1'b0, 1);
    advance(1'b1, 1'b0, '0, '0);
    do_fetch(32'h0000_0006, 1'b0, 0);

    // Predicted targets, including modulo wrap; error response loads IR
    advance(1'b0, 1'b1, 32'h8000_0100, 32'hFFFF_FFF0);
    do_fetch(32'h0000_0007, 1'b0, 1);
    advance(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0004);
    do_fetch(32'h0000_0008, 1'b1, 0);

    // bpu_busy stalls the IR for three cycles
    ir_ready = 1'b1; bpu_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_ir_valid", 32'(ir_valid), 32'd1);
      chk("busy_req_valid", 32'(ifu_req_valid), 32'd0);
      chk("busy_ir_pc", ir_pc, cur_ir_pc);
    end
    bpu_busy = 1'b0;
    advance(1'b1, 1'b0, '0, '0);

    // Flush during WAIT_RSP: late response must be dropped
    expect_req(pc);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h8000_0201;
    #1;
    chk("flush_ack_wait", 32'(pipe_flush_ack), 32'd1);
    step();
    pipe_flush_req = 1'b0;
    step();
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hDEAD_BEEF;
    step();
    ifu_rsp_valid = 1'b0;
    chk("discard_ir_valid", 32'(ir_valid), 32'd0);
    chk("discard_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
    exp_pc_q.push_back(32'h8000_0200);
    do_fetch(32'h0000_0009, 1'b0, 0);

    // Flush in REQ without handshake retargets the pending request
    advance(1'b1, 1'b0, '0, '0);
    expect_req(pc);
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_1000;
    step();
    pipe_flush_req = 1'b0;
    exp_pc_q.push_back(32'h0000_1000);
    do_fetch(32'h0000_000A, 1'b0, 0);

    // Reset in the middle of HOLD
    rst = 1'b1;
    #1;
    chk("midrst_ir_valid", 32'(ir_valid), 32'd0);
    chk("midrst_req_pc", ifu_req_pc, 32'h8000_0000);
    chk("midrst_req_valid", 32'(ifu_req_valid), 32'd1);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
